// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART byte transmitter among N_REQ requesters.
// Optional macro UART_TX_ARB_TAG_EN inserts a header tag byte (TAG_BASE | grant_id) before each grant's data.
module uart_tx_arbiter #(
    parameter int              N_REQ     = 4,
    parameter int              BYTE      = 8,
    parameter int              MAX_BURST = 16,
    parameter logic [BYTE-1:0] TAG_BASE  = 8'hA0
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*BYTE-1:0]      req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_valid,
    output logic [BYTE-1:0]            tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [PTR_W:0]   N_REQ_W   = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_BURST);
    localparam logic [BYTE-1:0]  OWNER_MSK = BYTE'(N_REQ - 1);

    // The tag is formed by OR-ing the owner index into TAG_BASE, so its low bits must be free.
    if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || (TAG_BASE & OWNER_MSK) != '0) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TAG    = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   grant_id_q, grant_id_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [PTR_W-1:0]   pick_s;
    logic               any_valid_s;
    logic               own_valid_s;
    logic               own_last_s;
    logic [BYTE-1:0]    own_data_s;
    logic [CNT_W-1:0]   burst_inc_s;
    logic               tx_valid_s;
    logic [BYTE-1:0]    tx_data_s;
    logic [N_REQ-1:0]   req_ready_s;
    logic               busy_s;

    // Round-robin search starting just after last_ptr; the lowest offset that has a request wins.
    always_comb begin
        logic [PTR_W:0] idx_v;
        idx_v       = '0;
        pick_s      = last_ptr_q;
        any_valid_s = |req_valid;
        for (int k = N_REQ; k >= 1; k--) begin
            idx_v = {1'b0, last_ptr_q} + (PTR_W + 1)'(k);
            if (idx_v >= N_REQ_W) begin
                idx_v = idx_v - N_REQ_W;
            end else begin
                idx_v = idx_v;
            end
            if (req_valid[idx_v[PTR_W-1:0]]) begin
                pick_s = idx_v[PTR_W-1:0];
            end else begin
                pick_s = pick_s;
            end
        end
    end

    // Current owner's request lines.
    always_comb begin
        own_valid_s = req_valid[grant_id_q];
        own_last_s  = req_last[grant_id_q];
        own_data_s  = req_data[int'(grant_id_q)*BYTE +: BYTE];
        burst_inc_s = burst_cnt_q + CNT_W'(1);
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        last_ptr_d  = last_ptr_q;
        burst_cnt_d = burst_cnt_q;
        tx_valid_s  = 1'b0;
        tx_data_s   = '0;
        req_ready_s = '0;
        busy_s      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_valid_s) begin
                    grant_id_d  = pick_s;
                    last_ptr_d  = pick_s;
                    burst_cnt_d = '0;
`ifdef UART_TX_ARB_TAG_EN
                    state_d     = S_TAG;
`else
                    state_d     = S_STREAM;
`endif
                end else begin
                    state_d     = S_IDLE;
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            S_TAG: begin
                tx_valid_s = 1'b1;
                tx_data_s  = TAG_BASE | BYTE'(grant_id_q);
                if (tx_ready) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_TAG;
                end
            end
`endif
            S_STREAM: begin
                tx_valid_s              = own_valid_s;
                tx_data_s               = own_data_s;
                req_ready_s[grant_id_q] = tx_ready;
                // The grant ends on the packet's last byte or when the burst budget is used up.
                if (own_valid_s && tx_ready) begin
                    burst_cnt_d = burst_inc_s;
                    if (own_last_s || (burst_inc_s == CNT_MAX)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; requester 0 has first priority after reset.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            grant_id_q  <= '0;
            last_ptr_q  <= PTR_LAST;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            last_ptr_q  <= last_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign req_ready = req_ready_s;
    assign tx_valid  = tx_valid_s;
    assign tx_data   = tx_data_s;
    assign grant_id  = grant_id_q;
    assign busy      = busy_s;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration order plus sequences for burst, stall and reset.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        areset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [1:0]  grant_id;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_arbiter #(.N_REQ(4), .BYTE(8), .MAX_BURST(16), .TAG_BASE(8'hA0)) dut (
        .clk(clk), .areset(areset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        rdy;
        logic        e_tv;
        logic [7:0]  e_td;
        logic [3:0]  e_rr;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                                input logic rdy, input logic e_tv, input logic [7:0] e_td,
                                input logic [3:0] e_rr, input logic e_busy, input logic [1:0] e_gid);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.rdy = rdy;
        r.e_tv = e_tv; r.e_td = e_td; r.e_rr = e_rr; r.e_busy = e_busy; r.e_gid = e_gid;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].v;
            req_data  = tbl[i].d;
            req_last  = tbl[i].l;
            tx_ready  = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("%s[%0d].tx_valid", tag, i), {31'd0, tx_valid}, {31'd0, tbl[i].e_tv});
            chk($sformatf("%s[%0d].tx_data", tag, i), {24'd0, tx_data}, {24'd0, tbl[i].e_td});
            chk($sformatf("%s[%0d].req_ready", tag, i), {28'd0, req_ready}, {28'd0, tbl[i].e_rr});
            chk($sformatf("%s[%0d].busy", tag, i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("%s[%0d].grant_id", tag, i), {30'd0, grant_id}, {30'd0, tbl[i].e_gid});
            @(posedge clk); #1;
        end
        tbl.delete();
    endtask

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] gid_q[$];

    task automatic cmp_stream(input string tag);
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s.byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int i0, i1, i3, t, bad_hot, bad_mirror, bad_hold;
        logic [7:0] b;
        logic       pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        areset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset.tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset.tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset.req_ready", {28'd0, req_ready}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.grant_id", {30'd0, grant_id}, 32'd0);
        @(posedge clk); #1;
        areset = 1'b0; req_valid = '0; tx_ready = 1'b1;

`ifdef UART_TX_ARB_TAG_EN
        tbl.push_back(mk(4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0000, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 32'h005A_0000, 4'b0100, 1'b1, 1'b1, 8'h5A, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
        run_table("tag");
`else
        // Two requesters contend twice: order 0,2,0,2 with one bubble between grants.
        tbl.push_back(mk(4'b0101, 32'h0021_0001, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0101, 32'h0021_0001, 4'b0000, 1'b1, 1'b1, 8'h01, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0101, 32'h0021_0002, 4'b0001, 1'b1, 1'b1, 8'h02, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0101, 32'h0021_0003, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0101, 32'h0021_0003, 4'b0000, 1'b1, 1'b1, 8'h21, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0101, 32'h0022_0003, 4'b0100, 1'b1, 1'b1, 8'h22, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0101, 32'h0023_0003, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
        tbl.push_back(mk(4'b0101, 32'h0023_0003, 4'b0000, 1'b1, 1'b1, 8'h03, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0101, 32'h0023_0004, 4'b0001, 1'b1, 1'b1, 8'h04, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0100, 32'h0023_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
        tbl.push_back(mk(4'b0100, 32'h0023_0000, 4'b0000, 1'b1, 1'b1, 8'h23, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0100, 32'h0024_0000, 4'b0100, 1'b1, 1'b1, 8'h24, 4'b0100, 1'b1, 2'd2));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
        // req0 alone, 3 bytes; the owner drops valid once while req2 waits.
        tbl.push_back(mk(4'b0001, 32'h0000_0011, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2));
        tbl.push_back(mk(4'b0001, 32'h0000_0011, 4'b0000, 1'b1, 1'b1, 8'h11, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0100, 32'h0099_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0001, 32'h0000_0022, 4'b0000, 1'b1, 1'b1, 8'h22, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0001, 32'h0000_0033, 4'b0001, 1'b1, 1'b1, 8'h33, 4'b0001, 1'b1, 2'd0));
        tbl.push_back(mk(4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0));
        run_table("rr");

        // req1 sends 20 bytes against a 16-byte burst limit while req3 has one byte pending.
        i1 = 0; i3 = 0; bad_hot = 0;
        for (int k = 0; k < 16; k++) exp_q.push_back(8'h40 + 8'(k));
        exp_q.push_back(8'h77);
        for (int k = 16; k < 20; k++) exp_q.push_back(8'h40 + 8'(k));
        for (int c = 0; c < 200 && (i1 < 20 || i3 < 1); c++) begin
            b = 8'h40 + 8'(i1);
            req_valid = {(i3 < 1), 1'b0, (i1 < 20), 1'b0};
            req_data  = {8'h77, 8'h00, b, 8'h00};
            req_last  = {1'b1, 1'b0, (i1 == 19), 1'b0};
            tx_ready  = 1'b1;
            @(negedge clk);
            if ($countones(req_ready) > 1) bad_hot++;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (gid_q.size() == 0 || gid_q[$] != grant_id) gid_q.push_back(grant_id);
            end
            if (req_ready[1] && req_valid[1]) i1++;
            if (req_ready[3] && req_valid[3]) i3++;
            @(posedge clk); #1;
        end
        req_valid = '0; req_last = '0;
        chk("burst.done", ((i1 == 20) && (i3 == 1)) ? 32'd1 : 32'd0, 32'd1);
        chk("burst.onehot", bad_hot, 32'd0);
        chk("burst.gid_count", gid_q.size(), 32'd3);
        if (gid_q.size() == 3) begin
            chk("burst.gid0", {30'd0, gid_q[0]}, 32'd1);
            chk("burst.gid1", {30'd0, gid_q[1]}, 32'd3);
            chk("burst.gid2", {30'd0, gid_q[2]}, 32'd1);
        end
        gid_q.delete();
        cmp_stream("burst");
        @(posedge clk); #1;

        // req0 sends 4 bytes while tx_ready cycles 1,0,0,1.
        i0 = 0; t = 0; bad_mirror = 0; bad_hold = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'h81 + 8'(k));
        for (int c = 0; c < 100 && i0 < 4; c++) begin
            req_valid = 4'b0001;
            req_data  = {24'd0, 8'h81 + 8'(i0)};
            req_last  = {3'b000, (i0 == 3)};
            tx_ready  = pat[t % 4];
            t++;
            @(negedge clk);
            if (busy && (req_ready[0] !== tx_ready)) bad_mirror++;
            if (tx_valid && (tx_data !== 8'h81 + 8'(i0))) bad_hold++;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (req_ready[0] && req_valid[0]) i0++;
            @(posedge clk); #1;
        end
        req_valid = '0; req_last = '0; tx_ready = 1'b1;
        chk("stall.done", i0, 32'd4);
        chk("stall.mirror", bad_mirror, 32'd0);
        chk("stall.hold", bad_hold, 32'd0);
        cmp_stream("stall");
        @(posedge clk); #1;

        // Reset after the second byte of a 5-byte req1 packet, then req0/req1 contention.
        i1 = 0;
        for (int c = 0; c < 50 && i1 < 2; c++) begin
            req_valid = 4'b0010;
            req_data  = {16'd0, 8'h61 + 8'(i1), 8'd0};
            req_last  = 4'b0000;
            tx_ready  = 1'b1;
            @(negedge clk);
            if (req_ready[1] && req_valid[1]) i1++;
            @(posedge clk); #1;
        end
        chk("rst.pre_bytes", i1, 32'd2);
        req_data = {16'd0, 8'h63, 8'd0};
        areset   = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        areset    = 1'b0;
        tx_ready  = 1'b1;
        req_valid = 4'b0011;
        req_data  = {16'd0, 8'h63, 8'hC1};
        req_last  = 4'b0001;
        @(negedge clk);
        chk("rst.tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.req_ready", {28'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.grant_id", {30'd0, grant_id}, 32'd0);
        chk("rst.req_ready0", {28'd0, req_ready}, 32'd1);
        chk("rst.tx_data", {24'd0, tx_data}, 32'hC1);
        chk("rst.tx_valid1", {31'd0, tx_valid}, 32'd1);
        @(posedge clk); #1;
        req_valid = '0; req_last = '0;
        @(posedge clk); #1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
